// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: frame-fetch FSM state encoding and the
// bytes-per-word helper used to convert between byte addresses and words.
package vga_pkg;

  // Frame-fetch FSM states (2-bit encoding kept for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Bytes per read-data word
  function automatic int unsigned bpw(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Burst address generator for the frame fetcher.
// Given the current burst start address and the frame end address it returns
// the burst length (words minus one), the address after the burst and whether
// that address wraps the frame. Also qualifies a base/top pair as a usable frame.
// Ports:
//   cur_addr   in   burst start byte address
//   frame_top  in   frame end byte address (exclusive)
//   cfg_base   in   candidate frame base from configuration
//   cfg_top    in   candidate frame top from configuration
//   len_m1     out  burst words minus one
//   next_addr  out  byte address following the burst
//   wrap       out  burst reaches the end of the frame
//   cfg_ok     out  cfg_top exceeds cfg_base by at least one word
module fetch_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [ADDR_WIDTH-1:0] frame_top,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_top,
  output logic [7:0]            len_m1,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap,
  output logic                  cfg_ok
);

  localparam int unsigned BPW       = bpw(DATA_WIDTH);
  localparam int unsigned BPW_SHIFT = $clog2(BPW);
  localparam int unsigned LEN_W     = $clog2(BURST_LEN) + 1;

  logic [ADDR_WIDTH-1:0] remain_words;
  logic [ADDR_WIDTH-1:0] top_gap;
  logic [ADDR_WIDTH-1:0] cfg_span;
  logic [LEN_W-1:0]      len_words;

  // Length clamp, advance and wrap detection
  always_comb begin
    remain_words = (frame_top - cur_addr) >> BPW_SHIFT;
    if (remain_words >= ADDR_WIDTH'(BURST_LEN)) begin
      len_words = LEN_W'(BURST_LEN);
    end else begin
      len_words = LEN_W'(remain_words);
    end
    len_m1    = 8'(len_words - LEN_W'(1));
    next_addr = cur_addr + (ADDR_WIDTH'(len_words) << BPW_SHIFT);
    // A trailing fragment shorter than one word cannot be fetched, so it wraps too
    top_gap   = frame_top - next_addr;
    wrap      = (next_addr >= frame_top) || (top_gap < ADDR_WIDTH'(BPW));
    cfg_span  = cfg_top - cfg_base;
    cfg_ok    = (cfg_top > cfg_base) && (cfg_span >= ADDR_WIDTH'(BPW));
  end

endmodule

// File: rtl/frame_fetch_ctrl.sv
// Frame-buffer fetch sequencer for the VGA pipeline.
// Walks memory from base to top in bursts of up to BURST_LEN words, filling a
// two-half ping-pong line buffer; the display side releases halves as it drains.
// Optional feature: define FETCH_UNDERRUN_CNT_EN to add underrun_cnt_o, a
// saturating count of consumer starts on an empty half.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   self_test_i             fetch disabled while high
//   base_addr_i/top_addr_i  frame byte range [base, top)
//   mem_req_o/addr/len      burst request, held until mem_ack_i
//   mem_ack_i               request accepted
//   mem_rvalid/rdata/rlast/rerr_i  read beat stream
//   buf_we/sel/waddr/wdata_o       buffer write port (aligned with the beat)
//   buf_full_o              half[i] holds valid data
//   buf_release_i           consumer done with half[i]
//   rd_start_i/rd_sel_i     consumer begins reading a half
//   frame_done_o            pulse when the last burst of a frame completes
//   fetch_err_o             sticky beat error for the current frame
//   underrun_cnt_o          (FETCH_UNDERRUN_CNT_EN only) underrun count
module frame_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         self_test_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        top_addr_i,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [7:0]                   mem_len_o,
  input  logic                         mem_ack_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
  input  logic                         mem_rlast_i,
  input  logic                         mem_rerr_i,
  output logic                         buf_we_o,
  output logic                         buf_sel_o,
  output logic [$clog2(BURST_LEN)-1:0] buf_waddr_o,
  output logic [DATA_WIDTH-1:0]        buf_wdata_o,
  output logic [1:0]                   buf_full_o,
  input  logic [1:0]                   buf_release_i,
  input  logic                         rd_start_i,
  input  logic                         rd_sel_i,
  output logic                         frame_done_o,
  output logic                         fetch_err_o
`ifdef FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(BURST_LEN);

  logic [1:0]            state, state_n;
  logic                  req_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [7:0]            len_n;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
  logic [ADDR_WIDTH-1:0] frame_base, frame_base_n;
  logic [ADDR_WIDTH-1:0] frame_top, frame_top_n;
  logic                  wr_half, wr_half_n;
  logic [IDX_W-1:0]      index, index_n;
  logic [1:0]            full_n;
  logic                  done_n;
  logic                  err_n;
  logic                  frame_start, frame_start_n;

  logic [ADDR_WIDTH-1:0] gen_cur, gen_top, gen_next;
  logic [7:0]            gen_len_m1;
  logic                  gen_wrap, cfg_ok;

  // In IDLE the generator sizes the first burst straight from the configuration
  assign gen_cur = (state == ST_IDLE) ? base_addr_i : cur_addr;
  assign gen_top = (state == ST_IDLE) ? top_addr_i  : frame_top;

  fetch_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) u_addr_gen (
    .cur_addr  (gen_cur),
    .frame_top (gen_top),
    .cfg_base  (base_addr_i),
    .cfg_top   (top_addr_i),
    .len_m1    (gen_len_m1),
    .next_addr (gen_next),
    .wrap      (gen_wrap),
    .cfg_ok    (cfg_ok)
  );

  // Buffer write port follows the beat in the same cycle
  assign buf_we_o    = !reset && (state == ST_DATA) && mem_rvalid_i;
  assign buf_sel_o   = wr_half;
  assign buf_waddr_o = index;
  assign buf_wdata_o = mem_rdata_i;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_len_o    <= '0;
      cur_addr     <= '0;
      frame_base   <= '0;
      frame_top    <= '0;
      wr_half      <= 1'b0;
      index        <= '0;
      buf_full_o   <= '0;
      frame_done_o <= 1'b0;
      fetch_err_o  <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_n;
      mem_req_o    <= req_n;
      mem_addr_o   <= addr_n;
      mem_len_o    <= len_n;
      cur_addr     <= cur_addr_n;
      frame_base   <= frame_base_n;
      frame_top    <= frame_top_n;
      wr_half      <= wr_half_n;
      index        <= index_n;
      buf_full_o   <= full_n;
      frame_done_o <= done_n;
      fetch_err_o  <= err_n;
      frame_start  <= frame_start_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n       = state;
    req_n         = mem_req_o;
    addr_n        = mem_addr_o;
    len_n         = mem_len_o;
    cur_addr_n    = cur_addr;
    frame_base_n  = frame_base;
    frame_top_n   = frame_top;
    wr_half_n     = wr_half;
    index_n       = index;
    full_n        = buf_full_o & ~buf_release_i;
    done_n        = 1'b0;
    err_n         = fetch_err_o;
    frame_start_n = frame_start;

    case (state)
      ST_IDLE: begin
        if (!self_test_i && cfg_ok) begin
          state_n       = ST_REQ;
          req_n         = 1'b1;
          addr_n        = base_addr_i;
          len_n         = gen_len_m1;
          cur_addr_n    = base_addr_i;
          frame_base_n  = base_addr_i;
          frame_top_n   = top_addr_i;
          err_n         = 1'b0;
          frame_start_n = 1'b0;
        end
      end

      ST_REQ: begin
        if (mem_ack_i) begin
          state_n = ST_DATA;
          req_n   = 1'b0;
          index_n = '0;
        end
      end

      ST_DATA: begin
        if (mem_rvalid_i) begin
          index_n = index + IDX_W'(1);
          if (mem_rerr_i) begin
            err_n = 1'b1;
          end
          if (mem_rlast_i) begin
            full_n[wr_half] = 1'b1;
            wr_half_n       = ~wr_half;
            index_n         = '0;
            if (gen_wrap) begin
              // New base/top are adopted only here, at the frame boundary
              if (cfg_ok) begin
                cur_addr_n   = base_addr_i;
                frame_base_n = base_addr_i;
                frame_top_n  = top_addr_i;
              end else begin
                cur_addr_n   = frame_base;
              end
              done_n        = 1'b1;
              frame_start_n = 1'b1;
            end else begin
              cur_addr_n = gen_next;
            end
            if (self_test_i) begin
              state_n   = ST_IDLE;
              full_n    = '0;
              wr_half_n = 1'b0;
            end else begin
              state_n = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        if (self_test_i) begin
          state_n   = ST_IDLE;
          full_n    = '0;
          wr_half_n = 1'b0;
        end else if (!buf_full_o[wr_half]) begin
          state_n = ST_REQ;
          req_n   = 1'b1;
          addr_n  = cur_addr;
          len_n   = gen_len_m1;
          if (frame_start) begin
            err_n         = 1'b0;
            frame_start_n = 1'b0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

`ifdef FETCH_UNDERRUN_CNT_EN
  // Saturating count of reads started on a half that is not yet filled
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt_o <= '0;
    end else if (rd_start_i && !buf_full_o[rd_sel_i] && (underrun_cnt_o != 16'hFFFF)) begin
      underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = rd_start_i | rd_sel_i;
`endif

endmodule
